// File: rtl/pattern_byte_gen.sv
// Byte-stream pattern generator: repeats a latched 32-bit word LSB byte first
// for a programmed number of repetitions, then switches to a PRBS-15 byte stream.
module pattern_byte_gen #(
  parameter logic [14:0] SEED  = 15'h7FFF,
  parameter int          REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      pattern,
  input  logic [REP_W-1:0] rep_n,
  output logic [7:0]       byte_out,
  output logic [1:0]       byte_num,
  output logic             valid,
  output logic             prbs_mode,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Output handshake: valid is a one-cycle qualifier for byte_out/byte_num;
  // there is no backpressure, the consumer must take every valid byte.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PATTERN = 2'd1,
    S_PRBS    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pat_q, pat_d;
  logic [REP_W-1:0] rep_n_q, rep_n_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [14:0]      lfsr_q, lfsr_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       byte_num_q, byte_num_d;
  logic             valid_q, valid_d;
  logic             prbs_q, prbs_d;

  logic [REP_W-1:0] cnt_inc;
  logic [31:0]      pat_shift;
  logic [22:0]      prbs_next;

  // Eight LFSR steps per byte; the first feedback bit lands in bit 7.
  function automatic logic [22:0] prbs_step8(input logic [14:0] s);
    logic [14:0] t;
    logic [7:0]  b;
    logic        f;
    t = s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      f = t[14] ^ t[13];
      b = {b[6:0], f};
      t = {t[13:0], f};
    end
    return {b, t};
  endfunction

  assign cnt_inc   = cnt_q + 1'b1;
  assign pat_shift = pat_q >> {idx_q, 3'b000};
  assign prbs_next = prbs_step8(lfsr_q);

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_n_d    = rep_n_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    byte_d     = byte_q;
    byte_num_d = byte_num_q;
    valid_d    = 1'b0;
    prbs_d     = prbs_q;

    if (stop) begin
      state_d    = S_IDLE;
      prbs_d     = 1'b0;
      byte_num_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_d   = pattern;
            rep_n_d = rep_n;
            lfsr_d  = SEED;
            idx_d   = 2'd0;
            cnt_d   = '0;
            state_d = (rep_n != '0) ? S_PATTERN : S_PRBS;
          end
        end
        S_PATTERN: begin
          if (enable) begin
            byte_d     = pat_shift[7:0];
            byte_num_d = idx_q;
            valid_d    = 1'b1;
            prbs_d     = 1'b0;
            idx_d      = idx_q + 2'd1;
            // A repetition completes on the last byte of the word.
            if (idx_q == 2'd3) begin
              cnt_d = cnt_inc;
              if (cnt_inc == rep_n_q) state_d = S_PRBS;
            end
          end
        end
        S_PRBS: begin
          if (enable) begin
            byte_d     = prbs_next[22:15];
            lfsr_d     = prbs_next[14:0];
            byte_num_d = idx_q;
            valid_d    = 1'b1;
            prbs_d     = 1'b1;
            idx_d      = idx_q + 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pat_q      <= 32'h0;
      rep_n_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      lfsr_q     <= SEED;
      byte_q     <= 8'h00;
      byte_num_q <= 2'd0;
      valid_q    <= 1'b0;
      prbs_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      rep_n_q    <= rep_n_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      byte_q     <= byte_d;
      byte_num_q <= byte_num_d;
      valid_q    <= valid_d;
      prbs_q     <= prbs_d;
    end
  end

  assign byte_out  = byte_q;
  assign byte_num  = byte_num_q;
  assign valid     = valid_q;
  assign prbs_mode = prbs_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pattern_byte_gen.sv
// Directed bench for pattern_byte_gen: expected bytes are queued as stimulus is
// issued and a monitor pops them whenever the generator presents a valid byte.
module tb_pattern_byte_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        start;
  logic        stop;
  logic [31:0] pattern;
  logic [7:0]  rep_n;
  logic [7:0]  byte_out;
  logic [1:0]  byte_num;
  logic        valid;
  logic        prbs_mode;
  logic        busy;
  logic [1:0]  state_dbg;

  // {prbs_mode, byte_num, byte_out}
  logic [10:0] exp_q[$];
  int          errors;
  int          checks;

  pattern_byte_gen #(.SEED(15'h7FFF), .REP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .pattern   (pattern),
    .rep_n     (rep_n),
    .byte_out  (byte_out),
    .byte_num  (byte_num),
    .valid     (valid),
    .prbs_mode (prbs_mode),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic p, input logic [1:0] n, input logic [7:0] b);
    exp_q.push_back({p, n, b});
  endtask

  // Drivers
  task automatic do_start(input logic [31:0] p, input logic [7:0] r);
    pattern = p;
    rep_n   = r;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic run_bytes(input int n);
    enable = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    enable = 1'b0;
  endtask

  task automatic do_stop(input logic [7:0] hold_byte);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_valid", valid, 0);
    check("stop_busy", busy, 0);
    check("stop_byte_num", byte_num, 0);
    check("stop_prbs_mode", prbs_mode, 0);
    check("stop_byte_hold", byte_out, hold_byte);
  endtask

  initial begin
    logic [7:0] gap_bytes [4];
    logic [10:0] got;
    logic [10:0] want;
    errors  = 0;
    checks  = 0;
    gap_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};

    // Scoreboard monitor, sampling on the falling edge
    fork
      forever begin
        @(negedge clk);
        if (rst && valid) begin
          got = {prbs_mode, byte_num, byte_out};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_unexpected: got %0h with empty expected queue at %0t", got, $time);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL stream_byte: got prbs/num/byte %0h expected %0h at %0t", got, want, $time);
            end
          end
        end
      end
    join_none

    // Reset held with every input active
    rst     = 1'b0;
    start   = 1'b1;
    enable  = 1'b1;
    stop    = 1'b1;
    pattern = 32'hA1B2C3D4;
    rep_n   = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_num", byte_num, 0);
    check("rst_valid", valid, 0);
    check("rst_prbs_mode", prbs_mode, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);

    // Release; start still high is accepted on the next edge
    rst    = 1'b1;
    stop   = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_no_valid", valid, 0);
    check("start_state_pattern", state_dbg, 1);

    // Two repetitions of A1B2C3D4 then PRBS
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 2'd0, 8'hD4);
      push_exp(0, 2'd1, 8'hC3);
      push_exp(0, 2'd2, 8'hB2);
      push_exp(0, 2'd3, 8'hA1);
    end
    push_exp(1, 2'd0, 8'h00);
    push_exp(1, 2'd1, 8'h02);
    run_bytes(10);
    check("rep2_state_prbs", state_dbg, 2);
    do_stop(8'h02);

    // rep_n = 0 goes straight to PRBS; stop on the third PRBS byte
    do_start(32'hCAFEF00D, 8'd0);
    check("rep0_state_prbs", state_dbg, 2);
    push_exp(1, 2'd0, 8'h00);
    push_exp(1, 2'd1, 8'h02);
    run_bytes(2);
    enable = 1'b1;
    do_stop(8'h02);
    enable = 1'b0;

    // Restart from the seed
    do_start(32'h0, 8'd0);
    push_exp(1, 2'd0, 8'h00);
    run_bytes(1);
    check("restart_prbs_mode", prbs_mode, 1);
    do_stop(8'h00);

    // Enable toggling: outputs hold and valid drops in the gaps
    do_start(32'h11223344, 8'd1);
    for (int i = 0; i < 4; i++) begin
      push_exp(0, i[1:0], gap_bytes[i]);
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      check("gap_valid", valid, 0);
      check("gap_byte_hold", byte_out, gap_bytes[i]);
      check("gap_num_hold", byte_num, i);
      check("gap_prbs_hold", prbs_mode, 0);
    end
    check("rep1_state_prbs", state_dbg, 2);
    do_stop(8'h11);

    // Async reset mid-pattern clears outputs without a clock edge
    do_start(32'hDEADBEEF, 8'd3);
    push_exp(0, 2'd0, 8'hEF);
    push_exp(0, 2'd1, 8'hBE);
    run_bytes(2);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_byte_out", byte_out, 0);
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_byte_num", byte_num, 0);
    check("arst_prbs_mode", prbs_mode, 0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Start while busy must not disturb the latched pattern or count
    do_start(32'h01020304, 8'd1);
    push_exp(0, 2'd0, 8'h04);
    run_bytes(1);
    do_start(32'hFFFFFFFF, 8'd0);
    check("busy_start_state", state_dbg, 1);
    push_exp(0, 2'd1, 8'h03);
    push_exp(0, 2'd2, 8'h02);
    push_exp(0, 2'd3, 8'h01);
    push_exp(1, 2'd0, 8'h00);
    run_bytes(4);
    do_stop(8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
